store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MemWriteM  input  1  memory-stage store request.
REQ-005 SHALL have port MemReadM  input  1  memory-stage load request; never asserted together with MemWriteM.
REQ-006 SHALL have port ByteM  input  1  1 = byte access, 0 = word access.
REQ-007 SHALL have port ALUOutM  input  32  byte address.
REQ-008 SHALL have port WriteDataM  input  32  store data.
REQ-009 SHALL have port ReadDataM  output  32  load result, valid in the cycle StallM=0 with MemReadM=1.
REQ-010 SHALL have port StallM  output  1  freezes the pipeline at and before the memory stage.
REQ-011 SHALL have port SbEmpty  output  1  buffer holds no entries.
REQ-012 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  30 (word address), mem_wdata  output  32, mem_be  output  4: backing-memory request.
REQ-013 SHALL have ports mem_ready  input  1 (request accepted this cycle), mem_rdata  input  32, mem_rvalid  input  1 (read data valid).

Function
REQ-014 SHALL hold a FIFO of DEPTH entries {word address[31:2], data[31:0], be[3:0]} with wrapping head/tail pointers and an occupancy count 0..DEPTH.
REQ-015 Store word: SHALL enqueue {ALUOutM[31:2], WriteDataM, 4'b1111}; store byte: data = WriteDataM[7:0] replicated in all lanes, be one-hot at ALUOutM[1:0].
REQ-016 A store SHALL enqueue at the clock edge where MemWriteM=1 and count<DEPTH, with StallM=0; if count==DEPTH, StallM=1 and nothing enqueues, even if a drain pops that cycle.
REQ-017 Load FSM states IDLE, LREQ, LWAIT: IDLE->LREQ on a load that needs memory; LREQ->LWAIT on mem_ready; LWAIT->IDLE on mem_rvalid.
REQ-018 In LREQ: mem_req=1, mem_we=0, mem_addr=ALUOutM[31:2], held stable until mem_ready; one read outstanding maximum.
REQ-019 In the mem_rvalid cycle: StallM=0, ReadDataM formatted combinationally from mem_rdata (word: full; byte: lane ALUOutM[1:0] zero-extended to 32 bits).
REQ-020 A load that needs memory SHALL have StallM=1 from its first cycle until the mem_rvalid cycle.
REQ-021 A load whose word address matches no buffered entry SHALL go to memory without waiting for drain.
REQ-022 Drain: when the load FSM is IDLE with no load needing memory this cycle and count>0, SHALL present the head entry with mem_req=1, mem_we=1; head pops on mem_ready.
REQ-023 Port priority: a load in LREQ/LWAIT owns the port; an accepted drain write completes before the load issues.
REQ-024 Count SHALL be incremented by push, decremented by pop, and unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-025 When the FSM is IDLE, MemReadM=0 and MemWriteM=0, StallM SHALL be 0; ReadDataM SHALL be 0 whenever no load completes this cycle.

Reset
REQ-026 Reset SHALL empty the buffer, losing any pending stores, and set count=0, pointers=0, FSM=IDLE.
REQ-027 During and after reset: StallM=0, SbEmpty=1, mem_req=0, mem_we=0, ReadDataM=0, mem_addr/mem_wdata/mem_be=0.
REQ-028 Reset asserted in LREQ/LWAIT SHALL abandon the read; a late mem_rvalid while IDLE SHALL be ignored.

Configuration
REQ-029 Macro STORE_FWD_EN defined: a load matching buffered entries SHALL merge bytes youngest-first from all matching entries; if the merge covers every required byte, it SHALL complete in the same cycle with StallM=0 and no memory access; otherwise it SHALL behave as without the macro.
REQ-030 Macro STORE_FWD_EN undefined: a load matching any buffered word address SHALL hold StallM=1 until no matching entry remains, then SHALL issue to memory.

Verification
REQ-031 Reset, then 4 word stores to 0x100..0x10C with mem_ready=0 -> count 4, SbEmpty=0; a 5th store -> StallM=1 and no enqueue.
REQ-032 From that state, set mem_ready=1 -> 4 writes in FIFO order, mem_addr 0x40..0x43, mem_be=4'hF; SbEmpty=1 after the 4th pop.
REQ-033 Store byte 0xAB to 0x201, then byte load 0x201 with STORE_FWD_EN -> ReadDataM=0x000000AB, StallM=0, mem_req stays 0.
REQ-034 Same as REQ-033 without the macro -> StallM=1 until drain, then a read of word 0x80; mem_rdata=0x1122AB44 -> ReadDataM=0x000000AB.
REQ-035 Word load 0x300 with an empty buffer, mem_ready after 2 cycles, mem_rvalid 3 cycles later -> StallM=1 for 5 cycles and 0 in the rvalid cycle.
REQ-036 Assert reset in LWAIT with 2 entries buffered -> SbEmpty=1, StallM=0, mem_req=0; the following mem_rvalid is ignored.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry store FIFO in front of a single-ported memory, plus a blocking load FSM.
// Define STORE_FWD_EN to let loads fully covered by buffered stores complete without a memory read.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic        ByteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        SbEmpty,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    typedef enum logic [1:0] {IDLE, LREQ, LWAIT} state_t;

    sb_entry_t     sb [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    state_t        state, state_nx;

    logic [29:0] word_addr;
    logic [3:0]  need_be;
    sb_entry_t   st_entry;
    logic        full, any_match, fwd_hit, ld_active, ld_go, drain, push, pop, rd_done;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;

    assign word_addr = ALUOutM[31:2];
    assign need_be   = ByteM ? (4'b0001 << ALUOutM[1:0]) : 4'b1111;
    assign st_entry  = {word_addr, (ByteM ? {4{WriteDataM[7:0]}} : WriteDataM), need_be};

    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && sb[head + AW'(k)].addr == word_addr)
                any_match = 1'b1;
        end
    end

`ifdef STORE_FWD_EN
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;

    // Walk oldest to youngest so younger stores overwrite older bytes.
    always_comb begin
        fwd_be   = '0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && sb[head + AW'(k)].addr == word_addr) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb[head + AW'(k)].be[b]) begin
                        fwd_be[b]          = 1'b1;
                        fwd_data[8*b +: 8] = sb[head + AW'(k)].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign fwd_hit = any_match && ((fwd_be & need_be) == need_be);
    assign ld_word = rd_done ? mem_rdata : fwd_data;
`else
    assign fwd_hit = 1'b0;
    assign ld_word = mem_rdata;
`endif

    assign full      = (count == CW'(DEPTH));
    assign ld_active = !reset && state == IDLE && MemReadM;
    assign ld_go     = ld_active && !any_match;
    // Drain yields to a load that can issue or forward now, but keeps running for a load blocked on a match.
    assign drain     = !reset && state == IDLE && count != '0 && !ld_go && !(ld_active && fwd_hit);
    assign push      = !reset && MemWriteM && !full;
    assign pop       = drain && mem_ready;
    assign rd_done   = !reset && state == LWAIT && mem_rvalid;

    assign SbEmpty = reset || count == '0;
    assign StallM  = !reset && ((MemWriteM && full) ||
                                (state == IDLE && MemReadM && !fwd_hit) ||
                                state == LREQ ||
                                (state == LWAIT && !mem_rvalid));

    assign ld_byte   = ld_word[{ALUOutM[1:0], 3'b000} +: 8];
    assign ReadDataM = (rd_done || (ld_active && fwd_hit)) ?
                       (ByteM ? {24'h0, ld_byte} : ld_word) : '0;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!reset && state == LREQ) begin
            mem_req  = 1'b1;
            mem_addr = word_addr;
        end else if (drain) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sb[head].addr;
            mem_wdata = sb[head].data;
            mem_be    = sb[head].be;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ld_go)      state_nx = LREQ;
            LREQ:    if (mem_ready)  state_nx = LWAIT;
            LWAIT:   if (mem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            if (push) begin
                sb[tail] <= st_entry;
                tail     <= tail + AW'(1);
            end
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios, then random store/load/idle traffic against
// an architectural memory model and an in-order write queue.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM, ByteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallM, SbEmpty, mem_req, mem_we, mem_ready, mem_rvalid;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ByteM(ByteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
        .SbEmpty(SbEmpty), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    ent_t        q[$];
    logic [31:0] bmem [8];
    logic [31:0] arch [8];
    int          kind, w, ln, wait_cnt, nm, widx, rd_cnt, rd_idx;
    logic        bsel, done, exp_full, rd_pend, acc_rd;
    ent_t        e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic sm();
        @(negedge clk);
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] wd, input logic b, input int lane);
        logic [31:0] r;
        r = b ? {24'h0, wd[8*lane +: 8]} : wd;
        return r;
    endfunction

    initial begin
        reset = 1; MemWriteM = 0; MemReadM = 0; ByteM = 0; ALUOutM = 0; WriteDataM = 0;
        mem_ready = 0; mem_rdata = 0; mem_rvalid = 0;
        nx(); nx();
        sm();
        chk("rst_stall", 32'(StallM), 0);
        chk("rst_empty", 32'(SbEmpty), 1);
        chk("rst_req", 32'({mem_req, mem_we}), 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_port", 32'(mem_addr) | mem_wdata | 32'(mem_be), 0);
        nx(); reset = 0;
        sm();
        chk("post_rst_empty", 32'(SbEmpty), 1);
        chk("post_rst_req", 32'(mem_req), 0);
        nx();

        // fill to DEPTH with memory not accepting, then a fifth store must stall
        for (int i = 0; i < 4; i++) begin
            MemWriteM = 1; ByteM = 0; ALUOutM = 32'h100 + 32'(4*i); WriteDataM = 32'hD000_0000 + 32'(i);
            sm(); chk("fill_stall", 32'(StallM), 0);
            nx();
        end
        ALUOutM = 32'h110; WriteDataM = 32'hDEAD;
        sm();
        chk("full_stall", 32'(StallM), 1);
        chk("full_nempty", 32'(SbEmpty), 0);
        nx(); MemWriteM = 0; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            sm();
            chk("drain_req", 32'({mem_req, mem_we}), 3);
            chk("drain_addr", 32'(mem_addr), 32'h40 + 32'(i));
            chk("drain_be", 32'(mem_be), 32'hF);
            chk("drain_data", mem_wdata, 32'hD000_0000 + 32'(i));
            nx();
        end
        mem_ready = 0;
        sm();
        chk("drained_empty", 32'(SbEmpty), 1);
        chk("drained_req", 32'(mem_req), 0);
        nx();

        // word load miss: ready in the third stall cycle, rvalid three cycles later
        MemReadM = 1; ByteM = 0; ALUOutM = 32'h300;
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c == 2);
            sm();
            chk("ld_stall", 32'(StallM), 1);
            if (c == 1) begin
                chk("ld_req", 32'({mem_req, mem_we}), 2);
                chk("ld_addr", 32'(mem_addr), 32'hC0);
            end
            nx();
        end
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        sm();
        chk("ld_done_stall", 32'(StallM), 0);
        chk("ld_data", ReadDataM, 32'hCAFE_F00D);
        nx(); MemReadM = 0; mem_rvalid = 0;
        sm();
        chk("idle_stall", 32'(StallM), 0);
        chk("idle_rdata", ReadDataM, 0);
        nx();

        // reset while a read is outstanding with two entries buffered
        MemWriteM = 1; ALUOutM = 32'h400; WriteDataM = 1; nx();
        ALUOutM = 32'h404; nx();
        MemWriteM = 0; MemReadM = 1; ALUOutM = 32'h500; nx();
        mem_ready = 1; nx(); mem_ready = 0;
        sm();
        chk("lwait_stall", 32'(StallM), 1);
        chk("lwait_nempty", 32'(SbEmpty), 0);
        nx(); reset = 1;
        sm();
        chk("rst_lw_empty", 32'(SbEmpty), 1);
        chk("rst_lw_stall", 32'(StallM), 0);
        chk("rst_lw_req", 32'(mem_req), 0);
        nx(); reset = 0; MemReadM = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        sm();
        chk("late_rv_stall", 32'(StallM), 0);
        chk("late_rv_rdata", ReadDataM, 0);
        chk("late_rv_req", 32'(mem_req), 0);
        chk("late_rv_empty", 32'(SbEmpty), 1);
        nx(); mem_rvalid = 0;

        // byte store then byte load of the same byte
        MemWriteM = 1; ByteM = 1; ALUOutM = 32'h201; WriteDataM = 32'h5555_55AB; nx();
        MemWriteM = 0; MemReadM = 1;
`ifdef STORE_FWD_EN
        sm();
        chk("fwd_stall", 32'(StallM), 0);
        chk("fwd_data", ReadDataM, 32'h0000_00AB);
        chk("fwd_no_req", 32'(mem_req), 0);
        nx(); MemReadM = 0; ByteM = 0; mem_ready = 1; nx(); mem_ready = 0;
        sm(); chk("fwd_drained", 32'(SbEmpty), 1);
        nx();
`else
        sm();
        chk("blk_stall0", 32'(StallM), 1);
        chk("blk_drain_req", 32'({mem_req, mem_we}), 3);
        chk("blk_drain_addr", 32'(mem_addr), 32'h80);
        chk("blk_drain_be", 32'(mem_be), 32'h2);
        chk("blk_drain_data", mem_wdata, 32'hABAB_ABAB);
        nx(); mem_ready = 1;
        sm(); chk("blk_stall1", 32'(StallM), 1);
        nx(); mem_ready = 0;
        sm();
        chk("blk_stall2", 32'(StallM), 1);
        chk("blk_empty", 32'(SbEmpty), 1);
        nx(); mem_ready = 1;
        sm();
        chk("blk_rd_req", 32'({mem_req, mem_we}), 2);
        chk("blk_rd_addr", 32'(mem_addr), 32'h80);
        nx(); mem_ready = 0;
        sm(); chk("blk_stall3", 32'(StallM), 1);
        nx(); mem_rvalid = 1; mem_rdata = 32'h1122_AB44;
        sm();
        chk("blk_done_stall", 32'(StallM), 0);
        chk("blk_data", ReadDataM, 32'h0000_00AB);
        nx(); mem_rvalid = 0; MemReadM = 0; ByteM = 0;
`endif

        // random traffic over 8 words with a randomly slow memory
        reset = 1; nx(); reset = 0;
        q.delete();
        rd_pend = 0; rd_cnt = 0; rd_idx = 0;
        for (int i = 0; i < 8; i++) begin
            bmem[i] = $urandom;
            arch[i] = bmem[i];
        end
        for (int n = 0; n < 660; n++) begin
            kind = (n >= 600) ? 9 : int'($urandom_range(0, 9));
            w = int'($urandom_range(0, 7));
            ln = int'($urandom_range(0, 3));
            bsel = 1'($urandom_range(0, 1));
            MemWriteM = (kind < 4);
            MemReadM = (kind >= 4 && kind < 8);
            ByteM = bsel;
            ALUOutM = 32'h100 + 32'(w*4 + ln);
            WriteDataM = $urandom;
            wait_cnt = 0;
            done = 0;
            while (!done) begin
                mem_ready = ($urandom_range(0, 2) != 0);
                mem_rvalid = rd_pend && rd_cnt == 0;
                mem_rdata = mem_rvalid ? bmem[rd_idx] : $urandom;
                sm();
                chk("sb_empty", 32'(SbEmpty), 32'(q.size() == 0));
                exp_full = (q.size() == DEPTH);
                acc_rd = mem_req && !mem_we && mem_ready;
                if (mem_req && mem_we && mem_ready) begin
                    if (q.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        chk("wr_addr", 32'(mem_addr), 32'(q[0].a));
                        chk("wr_data", mem_wdata, q[0].d);
                        chk("wr_be", 32'(mem_be), 32'(q[0].be));
                        widx = int'(mem_addr) - 'h40;
                        if (widx >= 0 && widx < 8)
                            for (int b = 0; b < 4; b++)
                                if (mem_be[b]) bmem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
                        void'(q.pop_front());
                    end
                end
                if (acc_rd) begin
                    chk("rd_is_load", 32'(MemReadM), 1);
                    chk("rd_addr", 32'(mem_addr), 32'h40 + 32'(w));
                    nm = 0;
                    foreach (q[i]) if (q[i].a == 30'(32'h40 + 32'(w))) nm++;
                    chk("rd_pending_store", nm, 0);
                end
                if (MemWriteM) begin
                    chk("st_stall", 32'(StallM), 32'(exp_full));
                    if (!StallM) begin
                        e.a = 30'(32'h40 + 32'(w));
                        e.d = bsel ? {4{WriteDataM[7:0]}} : WriteDataM;
                        e.be = bsel ? 4'(1 << ln) : 4'hF;
                        q.push_back(e);
                        if (bsel) arch[w][8*ln +: 8] = WriteDataM[7:0];
                        else arch[w] = WriteDataM;
                        done = 1;
                    end
                end else if (MemReadM) begin
                    if (!StallM) begin
                        chk("ld_result", ReadDataM, fmt(arch[w], bsel, ln));
                        done = 1;
                    end
                end else begin
                    chk("idle_no_stall", 32'(StallM), 0);
                    chk("idle_rdata_zero", ReadDataM, 0);
                    done = 1;
                end
                if (mem_rvalid) rd_pend = 0;
                else if (rd_pend) rd_cnt--;
                if (acc_rd) begin
                    rd_pend = 1;
                    rd_cnt = int'($urandom_range(0, 2));
                    rd_idx = w;
                end
                wait_cnt++;
                if (!done && wait_cnt > 300) begin
                    chk("timeout", 1, 0);
                    done = 1;
                end
                nx();
            end
        end
        MemWriteM = 0; MemReadM = 0; mem_ready = 0; mem_rvalid = 0;
        sm();
        chk("final_empty", 32'(SbEmpty), 1);
        for (int i = 0; i < 8; i++) chk("final_mem", bmem[i], arch[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
